// File: rtl/traffic_pkg.sv
// Shared traffic-system constants: pedestrian button FSM encoding and default
// timing for the button front-end and the junction controller phases.
package traffic_pkg;

    typedef logic [1:0] ped_state_t;

    localparam ped_state_t ST_IDLE     = 2'd0;
    localparam ped_state_t ST_DB_PRESS = 2'd1;
    localparam ped_state_t ST_PRESSED  = 2'd2;
    localparam ped_state_t ST_DB_REL   = 2'd3;

    // Button conditioner defaults, in clk cycles (1 Hz system clock)
    localparam int unsigned PED_DEBOUNCE_CYCLES = 3;
    localparam int unsigned PED_LOCKOUT_CYCLES  = 30;
    localparam int unsigned PED_STUCK_CYCLES    = 100;

    // Controller phase lengths, in seconds
    localparam int unsigned MAIN_GREEN_CYCLES = 120;
    localparam int unsigned PED_WALK_CYCLES   = 30;

    // True while the debounced button level is high
    function automatic logic is_debounced_high(input ped_state_t st);
        return (st == ST_PRESSED) || (st == ST_DB_REL);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop synchroniser for a single asynchronous bit; all flops reset to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button front-end: synchronise, debounce, latch a crossing request,
// hold off new requests after service and flag a button that stays pressed.
module ped_button_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES  = PED_LOCKOUT_CYCLES,
    parameter int unsigned STUCK_CYCLES    = PED_STUCK_CYCLES,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button_raw,
    input  logic             served,
    output logic             req_out,
    output logic             req_pulse,
    output logic             locked,
    output logic             stuck_fault,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(STUCK_CYCLES + 1);

    // The sample that enters a DB_* state is the first of the run, so the counter
    // only has to cover the remaining DEBOUNCE_CYCLES-1 samples.
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [LK_W-1:0] LK_LOAD  = LK_W'(LOCKOUT_CYCLES);
    localparam logic [ST_W-1:0] ST_LIMIT = ST_W'(STUCK_CYCLES);

    logic s;

    ped_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [ST_W-1:0]   stuck_cnt_q, stuck_cnt_d;
    logic              stuck_q, stuck_d;
    logic              req_q, req_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic press_edge;
    logic release_edge;
    logic accept;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (button_raw),
        .q    (s)
    );

    // Debounce FSM
    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        press_edge   = 1'b0;
        release_edge = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s) state_d = ST_DB_PRESS;
            end
            ST_DB_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d    = ST_PRESSED;
                    press_edge = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!s) state_d = ST_DB_REL;
            end
            ST_DB_REL: begin
                if (s) begin
                    state_d = ST_PRESSED;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d      = ST_IDLE;
                    release_edge = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            db_cnt_d = '0;
        end
    end

    // Service always beats a press completing in the same cycle
    assign accept = press_edge && !locked && !stuck_q && !served;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (served) begin
            lock_cnt_d = LK_LOAD;
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - LK_W'(1);
        end

        req_d = req_q;
        if (served) begin
            req_d = 1'b0;
        end else if (accept) begin
            req_d = 1'b1;
        end

        pulse_d = accept;

        count_d = count_q;
        if (accept && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Stuck counter numbers the debounced-high cycles, starting at 1 on the press edge
    always_comb begin
        stuck_cnt_d = '0;
        if (press_edge) begin
            stuck_cnt_d = ST_W'(1);
        end else if (is_debounced_high(state_q) && !release_edge) begin
            stuck_cnt_d = (stuck_cnt_q == ST_LIMIT) ? stuck_cnt_q : stuck_cnt_q + ST_W'(1);
        end

        stuck_d = stuck_q;
        if (release_edge) begin
            stuck_d = 1'b0;
        end else if (stuck_cnt_d >= ST_LIMIT) begin
            stuck_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            lock_cnt_q  <= '0;
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
            req_q       <= 1'b0;
            pulse_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
            req_q       <= req_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
        end
    end

    assign req_out     = req_q;
    assign req_pulse   = pulse_q;
    assign locked      = (lock_cnt_q != '0);
    assign stuck_fault = stuck_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Bench for ped_button_conditioner: segment table, directed corner sequences and a
// randomized run checked every cycle against a debounced-level reference model.
module tb_ped_button_conditioner;

    localparam int SYNC  = 2;
    localparam int DB    = 3;
    localparam int LOCK  = 30;
    localparam int STUCK = 100;
    localparam int CMAX  = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       button_raw = 1'b0;
    logic       served = 1'b0;
    logic       req_out, req_pulse, locked, stuck_fault;
    logic [7:0] press_count;

    logic       button2 = 1'b0;
    logic       served2 = 1'b0;
    logic       req_out2, req_pulse2, locked2, stuck_fault2;
    logic [1:0] press_count2;

    always #5 clk = ~clk;

    ped_button_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_raw (button_raw),
        .served     (served),
        .req_out    (req_out),
        .req_pulse  (req_pulse),
        .locked     (locked),
        .stuck_fault(stuck_fault),
        .press_count(press_count)
    );

    ped_button_conditioner #(
        .CNT_W(2)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_raw (button2),
        .served     (served2),
        .req_out    (req_out2),
        .req_pulse  (req_pulse2),
        .locked     (locked2),
        .stuck_fault(stuck_fault2),
        .press_count(press_count2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a debounced level flips once the last DB synchronised samples
    // all disagree with it; the synchronised sample is the raw level SYNC edges ago.
    bit m_rawq[$];
    bit m_sq[$];
    bit m_db, m_stuck, m_req, m_pulse;
    int m_high, m_lock, m_count;

    function automatic void model_reset();
        m_rawq = {};
        m_sq   = {};
        for (int i = 0; i < SYNC; i++) m_rawq.push_back(1'b0);
        for (int i = 0; i < DB; i++) m_sq.push_back(1'b0);
        m_db = 0; m_stuck = 0; m_req = 0; m_pulse = 0;
        m_high = 0; m_lock = 0; m_count = 0;
    endfunction

    function automatic void model_step(input bit raw, input bit srv);
        bit s_e, all1, all0, rise, fall, acc, was_locked, was_stuck;
        s_e = m_rawq.pop_front();
        m_rawq.push_back(raw);
        void'(m_sq.pop_front());
        m_sq.push_back(s_e);
        all1 = 1; all0 = 1;
        foreach (m_sq[i]) begin
            if (m_sq[i]) all0 = 0;
            else all1 = 0;
        end
        rise = !m_db && all1;
        fall = m_db && all0;
        was_locked = (m_lock > 0);
        was_stuck  = m_stuck;
        acc = rise && !was_locked && !was_stuck && !srv;
        m_pulse = acc;
        if (srv) m_lock = LOCK;
        else if (m_lock > 0) m_lock--;
        if (srv) m_req = 0;
        else if (acc) m_req = 1;
        if (acc && m_count < CMAX) m_count++;
        if (rise) begin
            m_db = 1; m_high = 1;
        end else if (fall) begin
            m_db = 0; m_high = 0; m_stuck = 0;
        end else if (m_db && m_high < STUCK) begin
            m_high++;
        end
        if (m_high >= STUCK) m_stuck = 1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic compare_model();
        chk("model.req_out", int'(req_out), int'(m_req));
        chk("model.req_pulse", int'(req_pulse), int'(m_pulse));
        chk("model.locked", int'(locked), int'(m_lock > 0));
        chk("model.stuck_fault", int'(stuck_fault), int'(m_stuck));
        chk("model.press_count", int'(press_count), m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(button_raw, served);
        #1;
        cyc++;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset.req_out", int'(req_out), 0);
        chk("reset.req_pulse", int'(req_pulse), 0);
        chk("reset.locked", int'(locked), 0);
        chk("reset.stuck_fault", int'(stuck_fault), 0);
        chk("reset.press_count", int'(press_count), 0);
        chk("reset.press_count2", int'(press_count2), 0);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rst_first;
        bit button;
        bit srv;
        int cycles;
        bit exp_req;
        bit exp_locked;
        int exp_count;
        int exp_pulses;
    } seg_t;

    seg_t segs[$];

    initial begin
        int pulses;
        int len;

        // clean press
        segs.push_back('{1, 1, 0, 10, 1, 0, 1, 1});
        segs.push_back('{0, 0, 0, 10, 1, 0, 1, 0});
        // bounce 1,0,1,0 then stable
        segs.push_back('{1, 1, 0, 1, 0, 0, 0, 0});
        segs.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
        segs.push_back('{0, 1, 0, 1, 0, 0, 0, 0});
        segs.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
        segs.push_back('{0, 1, 0, 10, 1, 0, 1, 1});
        segs.push_back('{0, 0, 0, 8, 1, 0, 1, 0});
        // service, press inside lockout, press after lockout
        segs.push_back('{1, 1, 0, 8, 1, 0, 1, 1});
        segs.push_back('{0, 0, 0, 8, 1, 0, 1, 0});
        segs.push_back('{0, 0, 1, 1, 0, 1, 1, 0});
        segs.push_back('{0, 0, 0, 4, 0, 1, 1, 0});
        segs.push_back('{0, 1, 0, 8, 0, 1, 1, 0});
        segs.push_back('{0, 0, 0, 8, 0, 1, 1, 0});
        segs.push_back('{0, 0, 0, 12, 0, 0, 1, 0});
        segs.push_back('{0, 1, 0, 8, 1, 0, 2, 1});
        segs.push_back('{0, 0, 0, 8, 1, 0, 2, 0});

        model_reset();
        for (int i = 0; i < segs.size(); i++) begin
            if (segs[i].rst_first) do_reset();
            button_raw = segs[i].button;
            served     = segs[i].srv;
            pulses     = 0;
            for (int c = 0; c < segs[i].cycles; c++) begin
                tick();
                if (req_pulse) pulses++;
            end
            served = 1'b0;
            chk($sformatf("seg%0d.req_out", i), int'(req_out), int'(segs[i].exp_req));
            chk($sformatf("seg%0d.locked", i), int'(locked), int'(segs[i].exp_locked));
            chk($sformatf("seg%0d.count", i), int'(press_count), segs[i].exp_count);
            chk($sformatf("seg%0d.pulses", i), pulses, segs[i].exp_pulses);
        end

        // exact press latency: pulse only after the 5th edge from the first sample
        do_reset();
        button_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("latency.pulse%0d", i), int'(req_pulse), int'(i == 5));
        end
        button_raw = 1'b0;
        repeat (8) tick();

        // served coincides with the acceptance edge
        do_reset();
        button_raw = 1'b1;
        repeat (4) tick();
        served = 1'b1;
        tick();
        served = 1'b0;
        chk("collision.req_out", int'(req_out), 0);
        chk("collision.req_pulse", int'(req_pulse), 0);
        chk("collision.count", int'(press_count), 0);
        chk("collision.locked", int'(locked), 1);
        button_raw = 1'b0;
        repeat (8) tick();

        // stuck button
        do_reset();
        button_raw = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 103) chk("stuck.early", int'(stuck_fault), 0);
            if (i == 104) chk("stuck.set", int'(stuck_fault), 1);
        end
        chk("stuck.req_out", int'(req_out), 1);
        button_raw = 1'b0;
        for (int i = 121; i <= 125; i++) begin
            tick();
            if (i == 124) chk("stuck.hold", int'(stuck_fault), 1);
            if (i == 125) chk("stuck.clear", int'(stuck_fault), 0);
        end
        chk("stuck.req_after", int'(req_out), 1);

        // reset in DB_PRESS with a request pending, button still held afterwards
        do_reset();
        button_raw = 1'b1;
        repeat (8) tick();
        button_raw = 1'b0;
        repeat (8) tick();
        button_raw = 1'b1;
        repeat (3) tick();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("fresh.pulse%0d", i), int'(req_pulse), int'(i == 5));
        end
        button_raw = 1'b0;

        // saturation with a 2-bit counter
        for (int n = 1; n <= 5; n++) begin
            button2 = 1'b1;
            repeat (8) tick();
            button2 = 1'b0;
            repeat (8) tick();
            chk($sformatf("sat.count%0d", n), int'(press_count2), (n < 3) ? n : 3);
        end

        // randomized runs against the model
        do_reset();
        for (int seg = 0; seg < 600; seg++) begin
            button_raw = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(90, 130))
                                               : int'($urandom_range(1, 6));
            for (int c = 0; c < len; c++) begin
                served = ($urandom_range(0, 24) == 0);
                tick();
            end
            served = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
